// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
// Holds FSM states, grant encoding and the wait counter width.
package mem_arb_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_IF,
    GRANT_DM,
    RESP
  } state_t;

  typedef enum logic {
    GNT_IF,
    GNT_DM
  } grant_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Wait counter for a granted memory access.
// Flags expiry once LIMIT-1 ack-less cycles have been counted.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters.
// Define ARB_RR_EN for alternating grants on ties (else DM wins).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_wstrb,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        err
);

  state_t state;
  state_t stateNext;
  grant_t pick;
  logic   inGrant;
  logic   grantGo;
  logic   ackHit;
  logic   timeoutHit;
  logic   expired;

  assign inGrant    = (state == GRANT_IF) || (state == GRANT_DM);
  assign grantGo    = (state == IDLE) && (if_req || dm_req);
  assign ackHit     = inGrant && mem_ack;
  assign timeoutHit = inGrant && !mem_ack && expired;

`ifdef ARB_RR_EN
  grant_t lastGrant;
  logic   tie;

  assign tie = if_req && dm_req;

  always_comb begin
    pick = GNT_IF;
    if (tie) begin
      pick = (lastGrant == GNT_IF) ? GNT_DM : GNT_IF;
    end else if (dm_req) begin
      pick = GNT_DM;
    end
  end

  // Only contested grants move the tie-breaker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastGrant <= GNT_IF;
    end else if (grantGo && tie) begin
      lastGrant <= pick;
    end
  end
`else
  always_comb begin
    pick = dm_req ? GNT_DM : GNT_IF;
  end
`endif

  mem_arb_timer #(
    .LIMIT(TIMEOUT_CYC)
  ) uTimer (
    .clk    (clk),
    .rst    (rst),
    .clr    (grantGo),
    .en     (inGrant && !mem_ack),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (grantGo) begin
          stateNext = (pick == GNT_DM) ? GRANT_DM : GRANT_IF;
        end
      end
      GRANT_IF, GRANT_DM: begin
        if (ackHit || timeoutHit) begin
          stateNext = RESP;
        end
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      err       <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      err      <= 1'b0;
      if (grantGo) begin
        mem_req <= 1'b1;
        if (pick == GNT_DM) begin
          mem_we    <= dm_we;
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
          mem_wstrb <= dm_wstrb;
        end else begin
          mem_we    <= 1'b0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
          mem_wstrb <= '0;
        end
      end else if (ackHit || timeoutHit) begin
        mem_req <= 1'b0;
        err     <= timeoutHit;
        if (state == GRANT_IF) begin
          if_valid <= 1'b1;
          if_rdata <= ackHit ? mem_rdata : '0;
        end else begin
          dm_valid <= 1'b1;
          if (timeoutHit) begin
            dm_rdata <= '0;
          end else if (!mem_we) begin
            dm_rdata <= mem_rdata;
          end
        end
      end
    end
  end

  assign stall = !rst && ((if_req && !if_valid) ||
                          (dm_req && !dm_valid));

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, max cycles granted access waits for mem_ack (2..255).
REQ-002 SHALL have ports: clk  input  1  clock, rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 if_req  input  1  fetch read request, held until if_valid; if_addr  input  32  fetch address.
REQ-005 if_rdata  output  32  fetch data; if_valid  output  1  one-cycle fetch completion pulse.
REQ-006 dm_req  input  1  data request, held until dm_valid; dm_we  input  1  write when 1; dm_addr  input  32; dm_wdata  input  32; dm_wstrb  input  4  byte enables.
REQ-007 dm_rdata  output  32  load data; dm_valid  output  1  one-cycle data completion pulse.
REQ-008 mem_req, mem_we  output  1; mem_addr, mem_wdata  output  32; mem_wstrb  output  4  shared memory port.
REQ-009 mem_ack  input  1  memory completion; mem_rdata  input  32  valid when mem_ack=1.
REQ-010 stall  output  1  pipeline freeze; err  output  1  one-cycle timeout pulse.

Function
REQ-011 SHALL implement FSM with states IDLE, GRANT_IF, GRANT_DM, RESP.
REQ-012 In IDLE with a pending request, SHALL grant one requester and move to GRANT_IF/GRANT_DM next edge.
REQ-013 Both requests in the same IDLE cycle: DM SHALL win (fixed priority) unless ARB_RR_EN is defined.
REQ-014 mem_req and all mem_* payload SHALL be registered, asserted the cycle after grant, and held stable until the mem_ack cycle inclusive.
REQ-015 On mem_ack in GRANT_x: SHALL capture mem_rdata (reads only), deassert mem_req next edge, go to RESP.
REQ-016 In RESP, SHALL pulse granted requester's valid for exactly one cycle, then return to IDLE; minimum request-to-valid latency is 3 cycles (grant, mem_req, ack same cycle as mem_req, valid).
REQ-017 DM writes SHALL pulse dm_valid and leave dm_rdata unchanged.
REQ-018 Requests arriving while not in IDLE SHALL wait; no request dropped.
REQ-019 mem_ack while in IDLE or RESP SHALL be ignored.
REQ-020 stall SHALL be combinational: (if_req & ~if_valid) | (dm_req & ~dm_valid).
REQ-021 8-bit wait counter SHALL clear at grant and increment each GRANT_x cycle without mem_ack.
REQ-022 Counter reaching TIMEOUT_CYC-1 without ack: SHALL deassert mem_req, pulse err, enter RESP with rdata forced to 32'h0.
REQ-023 mem_ack and timeout in same cycle: ack SHALL win, err stays 0.
REQ-024 if_rdata/dm_rdata SHALL hold last value between completions.

Reset
REQ-025 rst SHALL immediately force state IDLE, counter 0, and all outputs 0, including mid-transaction with mem_req high.
REQ-026 After rst deasserts, held requests SHALL be re-arbitrated from IDLE as new requests.

Configuration
REQ-027 Macro ARB_RR_EN defined: SHALL keep a last-grant bit (reset 0 = IF) and on simultaneous requests grant the requester not granted last.
REQ-028 ARB_RR_EN undefined: SHALL use fixed DM priority, no last-grant register.

Structure
REQ-029 Package mem_arb_pkg SHALL hold state enum, grant enum {GNT_IF, GNT_DM}, counter width constant.
REQ-030 Wait counter and timeout compare SHALL be sub-module mem_arb_timer (inputs clr, en; output expired).

Verification
REQ-031 if_req=1, addr 0x100, ack after 2 cycles, rdata 0xDEADBEEF -> if_valid pulse, if_rdata=0xDEADBEEF, stall low in the pulse's following cycle.
REQ-032 if_req and dm_req (read 0x200) same cycle, no ARB_RR_EN -> DM served first, IF second; with ARB_RR_EN after reset -> DM first, on next tie IF first.
REQ-033 dm write 0x300, wdata 0x12345678, wstrb 4'b0011 -> mem_* match and stay stable until ack; dm_rdata unchanged.
REQ-034 TIMEOUT_CYC=4, mem_ack never -> mem_req drops after 4 cycles, err pulse, dm_valid with dm_rdata=0.
REQ-035 rst asserted while mem_req high -> mem_req, stall-driving state, valid all 0 asynchronously; re-arbitration after release.
REQ-036 mem_ack on the expiry cycle -> normal completion, err=0.
